id_stage: RTL and testbench

//  RV32I decode stage: takes fetched instruction, drives register-file read ports, resolves operands

---
 rtl/id_stage.sv | 191 +++++++++++++++++++
 tb/tb_id_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage. Decodes the fetched instruction, drives the register-file
// read ports, resolves operands with EX/MEM forwarding, stalls on load-use
// hazards and registers the decoded result into the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [XLEN-1:0]    if_pc,
  input  logic [31:0]        if_inst,
  output logic               id_ready,
  output logic               re1,
  output logic               re2,
  output logic [RADDR_W-1:0] raddr1,
  output logic [RADDR_W-1:0] raddr2,
  input  logic [XLEN-1:0]    rdata1,
  input  logic [XLEN-1:0]    rdata2,
  input  logic               ex_fwd_we,
  input  logic [RADDR_W-1:0] ex_fwd_waddr,
  input  logic [XLEN-1:0]    ex_fwd_wdata,
  input  logic               ex_is_load,
  input  logic               mem_fwd_we,
  input  logic [RADDR_W-1:0] mem_fwd_waddr,
  input  logic [XLEN-1:0]    mem_fwd_wdata,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [3:0]         ex_class,
  output logic [2:0]         ex_funct3,
  output logic               ex_alt,
  output logic [XLEN-1:0]    ex_opnd1,
  output logic [XLEN-1:0]    ex_opnd2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_wreg,
  output logic               ex_illegal
);

  typedef enum logic [3:0] {
    CLS_NOP   = 4'd0, CLS_LUI   = 4'd1, CLS_AUIPC = 4'd2, CLS_JAL   = 4'd3,
    CLS_JALR  = 4'd4, CLS_BRANCH = 4'd5, CLS_LOAD = 4'd6, CLS_STORE = 4'd7,
    CLS_OPIMM = 4'd8, CLS_OP    = 4'd9
  } cls_e;

  cls_e               cls_s;
  logic               illegal_s;
  logic               re1_s, re2_s, wreg_s, alt_s;
  logic [XLEN-1:0]    imm_s;
  logic [RADDR_W-1:0] rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0]    opnd1_s, opnd2_s;
  logic               hazard_s, advance_s;

  assign rs1_s = if_inst[19:15];
  assign rs2_s = if_inst[24:20];

  // Operand source: x0/unused reads give zero, EX result beats MEM result, else register file.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic en, input logic [RADDR_W-1:0] rs, input logic [XLEN-1:0] rf,
    input logic exw, input logic [RADDR_W-1:0] exa, input logic [XLEN-1:0] exd, input logic exl,
    input logic mw, input logic [RADDR_W-1:0] ma, input logic [XLEN-1:0] md);
    logic [XLEN-1:0] v;
    if (!en || rs == {RADDR_W{1'b0}}) v = {XLEN{1'b0}};
    else if (exw && exa == rs && !exl) v = exd;
    else if (mw && ma == rs) v = md;
    else v = rf;
    return v;
  endfunction

  // Opcode classification; anything unrecognised decodes as an illegal NOP.
  always_comb begin
    cls_s     = CLS_NOP;
    illegal_s = 1'b0;
    case (if_inst[6:0])
      7'b0110111: cls_s = CLS_LUI;
      7'b0010111: cls_s = CLS_AUIPC;
      7'b1101111: cls_s = CLS_JAL;
      7'b1100111: cls_s = CLS_JALR;
      7'b1100011: cls_s = CLS_BRANCH;
      7'b0000011: cls_s = CLS_LOAD;
      7'b0100011: cls_s = CLS_STORE;
      7'b0010011: cls_s = CLS_OPIMM;
      7'b0110011: cls_s = CLS_OP;
      default:    illegal_s = 1'b1;
    endcase
  end

  // Per-class read enables, immediate format, destination write and alt bit.
  always_comb begin
    re1_s  = 1'b0;
    re2_s  = 1'b0;
    wreg_s = 1'b0;
    alt_s  = 1'b0;
    imm_s  = {XLEN{1'b0}};
    case (cls_s)
      CLS_LUI, CLS_AUIPC: begin
        wreg_s = 1'b1;
        imm_s  = {if_inst[31:12], 12'h000};
      end
      CLS_JAL: begin
        wreg_s = 1'b1;
        imm_s  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
      end
      CLS_JALR, CLS_LOAD: begin
        re1_s  = 1'b1;
        wreg_s = 1'b1;
        imm_s  = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      CLS_OPIMM: begin
        re1_s  = 1'b1;
        wreg_s = 1'b1;
        imm_s  = {{20{if_inst[31]}}, if_inst[31:20]};
        if (if_inst[13:12] == 2'b01) alt_s = if_inst[30];
        else alt_s = 1'b0;
      end
      CLS_BRANCH: begin
        re1_s = 1'b1;
        re2_s = 1'b1;
        imm_s = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
      end
      CLS_STORE: begin
        re1_s = 1'b1;
        re2_s = 1'b1;
        imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      end
      CLS_OP: begin
        re1_s  = 1'b1;
        re2_s  = 1'b1;
        wreg_s = 1'b1;
        alt_s  = if_inst[30];
      end
      default: begin
        re1_s = 1'b0;
      end
    endcase
    if (if_inst[11:7] == 5'd0) wreg_s = 1'b0;
    else wreg_s = wreg_s;
  end

  assign rd_s    = wreg_s ? if_inst[11:7] : {RADDR_W{1'b0}};
  assign opnd1_s = fwd_sel(re1_s, rs1_s, rdata1, ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata, ex_is_load,
                           mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);
  assign opnd2_s = fwd_sel(re2_s, rs2_s, rdata2, ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata, ex_is_load,
                           mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);

  // A load in EX cannot forward its data yet, so a dependent read must wait a cycle.
  assign hazard_s  = ex_is_load && ex_fwd_we && (ex_fwd_waddr != {RADDR_W{1'b0}}) &&
                     ((re1_s && rs1_s == ex_fwd_waddr) || (re2_s && rs2_s == ex_fwd_waddr));
  assign advance_s = !ex_valid || ex_ready;
  assign id_ready  = flush || (advance_s && !hazard_s);
  assign re1       = re1_s;
  assign re2       = re2_s;
  assign raddr1    = rs1_s;
  assign raddr2    = rs2_s;

  // ID/EX pipeline register: flush kills, advance loads decode (bubble on hazard), else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= {XLEN{1'b0}};
      ex_class   <= 4'd0;
      ex_funct3  <= 3'd0;
      ex_alt     <= 1'b0;
      ex_opnd1   <= {XLEN{1'b0}};
      ex_opnd2   <= {XLEN{1'b0}};
      ex_imm     <= {XLEN{1'b0}};
      ex_rd      <= {RADDR_W{1'b0}};
      ex_wreg    <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance_s) begin
      ex_valid   <= if_valid && !hazard_s;
      ex_pc      <= if_pc;
      ex_class   <= cls_s;
      ex_funct3  <= if_inst[14:12];
      ex_alt     <= alt_s;
      ex_opnd1   <= opnd1_s;
      ex_opnd2   <= opnd2_s;
      ex_imm     <= imm_s;
      ex_rd      <= rd_s;
      ex_wreg    <= wreg_s;
      ex_illegal <= illegal_s;
    end else begin
      ex_valid <= ex_valid;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomised scoreboard bench for id_stage with directed opening scenarios.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        id_ready, re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_fwd_we, ex_is_load, mem_fwd_we, flush, ex_ready;
  logic [4:0]  ex_fwd_waddr, mem_fwd_waddr;
  logic [31:0] ex_fwd_wdata, mem_fwd_wdata;
  logic        ex_valid, ex_alt, ex_wreg, ex_illegal;
  logic [31:0] ex_pc, ex_opnd1, ex_opnd2, ex_imm;
  logic [3:0]  ex_class;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_ready(id_ready), .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .ex_fwd_we(ex_fwd_we), .ex_fwd_waddr(ex_fwd_waddr),
    .ex_fwd_wdata(ex_fwd_wdata), .ex_is_load(ex_is_load), .mem_fwd_we(mem_fwd_we),
    .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_class(ex_class),
    .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_opnd1(ex_opnd1), .ex_opnd2(ex_opnd2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  typedef struct {
    logic [31:0] pc, o1, o2, imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt, wreg, ill;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic m_valid = 1'b0;
  logic mon_en = 1'b0;
  logic [31:0] saved_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] w);
    case (w[6:0])
      7'h37: return 1;  7'h17: return 2;  7'h6F: return 3;  7'h67: return 4;
      7'h63: return 5;  7'h03: return 6;  7'h23: return 7;  7'h13: return 8;
      7'h33: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic bit reads1(input int c); return c inside {4, 5, 6, 7, 8, 9}; endfunction
  function automatic bit reads2(input int c); return c inside {5, 7, 9}; endfunction

  // Sign-extended immediate built by arithmetic on the instruction bit fields.
  function automatic logic [31:0] imm_of(input logic [31:0] w, input int c);
    int sgn;
    int v;
    sgn = w[31] ? 1 : 0;
    case (c)
      1, 2:    v = int'(w & 32'hFFFF_F000);
      3:       v = -sgn * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      4, 6, 8: v = -sgn * 2048 + int'(w[30:20]);
      5:       v = -sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      7:       v = -sgn * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] operand(input bit en, input logic [4:0] rs);
    if (!en || rs == 5'd0) return 32'd0;
    if (ex_fwd_we && !ex_is_load && ex_fwd_waddr == rs) return ex_fwd_wdata;
    if (mem_fwd_we && mem_fwd_waddr == rs) return mem_fwd_wdata;
    return regs[rs];
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   c;
    c     = cls_of(if_inst);
    e.pc  = if_pc;
    e.cls = 4'(c);
    e.f3  = if_inst[14:12];
    e.ill = (c == 0);
    e.alt = (c == 9 || (c == 8 && (if_inst[14:12] == 3'd1 || if_inst[14:12] == 3'd5))) ? if_inst[30] : 1'b0;
    e.wreg = (c inside {1, 2, 3, 4, 6, 8, 9}) && (if_inst[11:7] != 5'd0);
    e.rd  = e.wreg ? if_inst[11:7] : 5'd0;
    e.imm = imm_of(if_inst, c);
    e.o1  = operand(reads1(c), if_inst[19:15]);
    e.o2  = operand(reads2(c), if_inst[24:20]);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;  9: w = 32'hFFFF_FFFF;
      default: w[6:0] = 7'h0B;
    endcase
    return w;
  endfunction

  task automatic quiet_inputs();
    rst = 1'b0; if_valid = 1'b1; if_pc = 32'h0000_1000; if_inst = 32'h0000_0013;
    ex_fwd_we = 1'b0; ex_fwd_waddr = 5'd0; ex_fwd_wdata = 32'd0; ex_is_load = 1'b0;
    mem_fwd_we = 1'b0; mem_fwd_waddr = 5'd0; mem_fwd_wdata = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic rand_inputs();
    rst = ($urandom_range(0, 99) == 0);
    if_valid = ($urandom_range(0, 99) < 85);
    if_pc = $urandom & 32'hFFFF_FFFC;
    if_inst = gen_inst();
    ex_fwd_we = 1'($urandom_range(0, 1)); ex_fwd_waddr = 5'($urandom_range(0, 7));
    ex_fwd_wdata = $urandom; ex_is_load = ($urandom_range(0, 3) == 0);
    mem_fwd_we = 1'($urandom_range(0, 1)); mem_fwd_waddr = 5'($urandom_range(0, 7));
    mem_fwd_wdata = $urandom;
    flush = ($urandom_range(0, 99) < 8);
    ex_ready = ($urandom_range(0, 99) < 75);
  endtask

  // Called right after inputs change on the falling edge; checks comb outputs, issues expectations.
  task automatic step();
    int   c;
    logic hz, adv, nxt;
    #2;
    c   = cls_of(if_inst);
    hz  = ex_is_load && ex_fwd_we && ex_fwd_waddr != 5'd0 &&
          ((reads1(c) && if_inst[19:15] == ex_fwd_waddr) || (reads2(c) && if_inst[24:20] == ex_fwd_waddr));
    adv = !m_valid || ex_ready;
    if (rst) begin
      nxt = 1'b0;
    end else begin
      chk("id_ready", id_ready, flush || (adv && !hz));
      chk("re1", re1, reads1(c));
      chk("re2", re2, reads2(c));
      chk("raddr1", raddr1, if_inst[19:15]);
      chk("raddr2", raddr2, if_inst[24:20]);
      if (flush) nxt = 1'b0;
      else if (adv) begin
        nxt = if_valid && !hz;
        if (nxt) sb.push_back(model());
      end else nxt = m_valid;
    end
    @(posedge clk);
    #1;
    m_valid = nxt;
    if (rst) sb.delete();
  endtask

  // Monitor: whenever ID/EX content leaves (taken by EX or killed), compare it with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        chk("ex_valid", ex_valid, m_valid);
        if (ex_valid && (ex_ready || flush)) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_empty: got ex_valid=1, expected no pending instruction");
          end else begin
            e = sb.pop_front();
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_class", ex_class, e.cls);
            chk("ex_funct3", ex_funct3, e.f3);
            chk("ex_alt", ex_alt, e.alt);
            chk("ex_opnd1", ex_opnd1, e.o1);
            chk("ex_opnd2", ex_opnd2, e.o2);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_rd", ex_rd, e.rd);
            chk("ex_wreg", ex_wreg, e.wreg);
            chk("ex_illegal", ex_illegal, e.ill);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    quiet_inputs();
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_class", ex_class, 4'd0);
    chk("rst_ex_wreg", ex_wreg, 1'b0);

    // addi x1,x0,5
    @(negedge clk); quiet_inputs(); if_inst = 32'h0050_0093; step();
    chk("t1_valid", ex_valid, 1'b1);
    chk("t1_class", ex_class, 4'd8);
    chk("t1_imm", ex_imm, 32'd5);
    chk("t1_rd", ex_rd, 5'd1);
    chk("t1_opnd1", ex_opnd1, 32'd0);
    chk("t1_wreg", ex_wreg, 1'b1);

    // add x3,x1,x2 with EX and MEM both forwarding x1
    regs[1] = 32'd7; regs[2] = 32'd9;
    @(negedge clk); quiet_inputs(); if_inst = 32'h0020_81B3;
    ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'h11;
    mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'h22;
    step();
    chk("t2_opnd1", ex_opnd1, 32'h11);
    chk("t2_opnd2", ex_opnd2, 32'd9);

    // load to x5 in EX, then add x6,x5,x5
    @(negedge clk); quiet_inputs(); if_inst = 32'h0052_8333;
    ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd5; ex_is_load = 1'b1;
    #2; chk("t3_stall_ready", id_ready, 1'b0); #0; step();
    chk("t3_bubble", ex_valid, 1'b0);
    @(negedge clk); quiet_inputs(); if_inst = 32'h0052_8333;
    mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd5; mem_fwd_wdata = 32'h0000_ABCD;
    step();
    chk("t3_opnd1", ex_opnd1, 32'h0000_ABCD);
    chk("t3_opnd2", ex_opnd2, 32'h0000_ABCD);

    // EX back-pressure for three cycles
    @(negedge clk); quiet_inputs(); if_pc = 32'h0000_2000; if_inst = 32'h0050_0093; step();
    saved_pc = ex_pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); quiet_inputs(); if_pc = 32'h0000_3000; ex_ready = 1'b0; step();
    end
    chk("t4_hold_pc", ex_pc, saved_pc);
    chk("t4_hold_valid", ex_valid, 1'b1);
    @(negedge clk); quiet_inputs(); step();

    // flush with a valid beq, then flush together with a load-use hazard
    @(negedge clk); quiet_inputs(); if_inst = 32'h0020_8063; flush = 1'b1; step();
    chk("t5_flush", ex_valid, 1'b0);
    @(negedge clk); quiet_inputs(); if_inst = 32'h0020_8063; flush = 1'b1;
    ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd1; ex_is_load = 1'b1; step();
    chk("t5_flush_hz", ex_valid, 1'b0);

    // all-ones instruction with forwarding aimed at x0
    @(negedge clk); quiet_inputs(); if_inst = 32'hFFFF_FFFF;
    ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd0; ex_fwd_wdata = 32'h55;
    mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd0; mem_fwd_wdata = 32'h66; step();
    chk("t6_illegal", ex_illegal, 1'b1);
    chk("t6_class", ex_class, 4'd0);
    chk("t6_wreg", ex_wreg, 1'b0);
    chk("t6_opnd1", ex_opnd1, 32'd0);

    // reset while stalled behind EX back-pressure
    @(negedge clk); quiet_inputs(); ex_ready = 1'b0; step();
    @(negedge clk); quiet_inputs(); ex_ready = 1'b0; rst = 1'b1; step();
    chk("rst_mid_valid", ex_valid, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); rand_inputs(); step();
    end

    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
